scale_sequencer: RTL

- Line-rate controller for one horizontal fractional interpolator in the scandoubler/scaler path.
- From source, destination and display widths it computes the interpolator's step size with a serial divider, plus its centring offset and blanking limit.
- Each output line it pulses the interpolator's step reset, then gates its per-pixel step enable across the display's active span.
- It recomputes parameters whenever the width configuration changes. It never lets a line run with half-updated parameters.

---
 rtl/scale_sequencer_pkg.sv | 17 +
 rtl/scale_sequencer_frac_divider.sv | 72 +++++++
 rtl/scale_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/scale_sequencer_pkg.sv
// Shared definitions for the horizontal scale sequencer: default widths,
// sequencer state encoding and the fixed step-size constants.
package scale_sequencer_pkg;

    localparam int DEF_BITWIDTH  = 10;
    localparam int DEF_FRACWIDTH = 16;
    localparam int DEF_STEP_W    = DEF_BITWIDTH + DEF_FRACWIDTH;

    localparam logic [1:0] ST_CALC  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESET = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [DEF_STEP_W-1:0] UNITY_STEP = DEF_STEP_W'(1) << DEF_FRACWIDTH;
    localparam logic [DEF_STEP_W-1:0] SAT_STEP   = '1;

endpackage

// File: rtl/scale_sequencer_frac_divider.sv
// Serial restoring divider, one quotient bit per cycle; the first bit is
// produced on the start cycle itself so a divide takes dividend_w cycles.
module frac_divider #(
    parameter int dividend_w = 26,
    parameter int divisor_w  = 10,
    parameter int quotient_w = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [dividend_w-1:0] dividend,
    input  logic [divisor_w-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [quotient_w-1:0] quotient,
    output logic                  overflow
);

    localparam int cnt_w = $clog2(dividend_w + 1);

    logic [divisor_w-1:0]  rem, div_r, rem_cur, div_cur, rem_nxt;
    logic [dividend_w-1:0] work, work_cur, work_nxt;
    logic [divisor_w:0]    trial, diff;
    logic [cnt_w-1:0]      count;
    logic                  take;

    // NOTE: every always_comb output is assigned on every path, so no latch can form.
    always_comb begin
        rem_cur  = start ? '0 : rem;
        work_cur = start ? dividend : work;
        div_cur  = start ? divisor : div_r;
        trial    = {rem_cur, work_cur[dividend_w-1]};
        diff     = trial - {1'b0, div_cur};
        take     = (trial >= {1'b0, div_cur});
        rem_nxt  = take ? diff[divisor_w-1:0] : trial[divisor_w-1:0];
        work_nxt = {work_cur[dividend_w-2:0], take};
    end

    // Quotient bits shift into the low end of work as dividend bits leave the top.
    assign quotient = work[quotient_w-1:0];
    assign overflow = ((work >> quotient_w) != '0) || (div_r == '0);

    // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            rem   <= '0;
            work  <= '0;
            div_r <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= rem_nxt;
                work  <= work_nxt;
                div_r <= divisor;
                count <= cnt_w'(dividend_w - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem   <= rem_nxt;
                work  <= work_nxt;
                count <= count - 1'b1;
                if (count == cnt_w'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scale_sequencer.sv
// Line-rate controller for a horizontal fractional interpolator: computes
// step/offset/limit from the width configuration and sequences each line.
module scale_sequencer
    import scale_sequencer_pkg::*;
#(
    parameter int bitwidth  = DEF_BITWIDTH,
    parameter int fracwidth = DEF_FRACWIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [bitwidth-1:0]           src_width,
    input  logic [bitwidth-1:0]           dst_width,
    input  logic [bitwidth-1:0]           disp_width,
    input  logic                          line_start,
    input  logic                          pix_ce,
    output logic [bitwidth+fracwidth-1:0] stepsize,
    output logic [bitwidth-1:0]           offset,
    output logic [bitwidth-1:0]           limit,
    output logic                          step_reset,
    output logic                          step_in,
    output logic                          cfg_valid,
    output logic                          line_active
);

    localparam int step_w = bitwidth + fracwidth;
    localparam logic [step_w-1:0] unity_step = step_w'(1) << fracwidth;
    localparam logic [step_w-1:0] sat_step   = '1;

    logic [1:0]          state;
    logic [bitwidth-1:0] src_q, dst_q, disp_q;
    logic [bitwidth-1:0] src_l, dst_l, disp_l;
    logic [bitwidth-1:0] count, offset_nxt;
    logic [step_w-1:0]   quotient, step_nxt;
    logic                kick, params_ok;
    logic                cfg_diff, relatch, div_start, calc_done;
    logic                div_busy, div_done, div_ovf;

    assign cfg_diff  = {src_q, dst_q, disp_q} != {src_l, dst_l, disp_l};
    // A running line keeps its parameters; the relatch waits until it ends.
    assign relatch   = cfg_diff && (state == ST_CALC || state == ST_WAIT);
    assign div_start = relatch || (state == ST_CALC && kick);
    assign calc_done = (state == ST_CALC) && !div_start &&
                       ((dst_l == '0) || (div_done && !div_busy));
    assign line_active = (state == ST_RUN);

    frac_divider #(
        .dividend_w (step_w),
        .divisor_w  (bitwidth),
        .quotient_w (step_w)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend ({src_q, {fracwidth{1'b0}}}),
        .divisor  (dst_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient),
        .overflow (div_ovf)
    );

    always_comb begin
        offset_nxt = '0;
        if (disp_l > dst_l) offset_nxt = (disp_l - dst_l) >> 1;
        step_nxt = quotient;
        if (dst_l == '0 || div_ovf) step_nxt = sat_step;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_CALC;
            kick       <= 1'b1;
            params_ok  <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            disp_q     <= '0;
            src_l      <= '0;
            dst_l      <= '0;
            disp_l     <= '0;
            count      <= '0;
            stepsize   <= unity_step;
            offset     <= '0;
            limit      <= '0;
            step_reset <= 1'b0;
            step_in    <= 1'b0;
            cfg_valid  <= 1'b0;
        end else begin
            src_q      <= src_width;
            dst_q      <= dst_width;
            disp_q     <= disp_width;
            kick       <= 1'b0;
            step_reset <= 1'b0;
            step_in    <= 1'b0;
            cfg_valid  <= params_ok && !cfg_diff;

            if (relatch) begin
                src_l     <= src_q;
                dst_l     <= dst_q;
                disp_l    <= disp_q;
                params_ok <= 1'b0;
            end

            case (state)
                ST_CALC: begin
                    if (calc_done) begin
                        stepsize  <= step_nxt;
                        offset    <= offset_nxt;
                        limit     <= src_l;
                        params_ok <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (relatch) begin
                        state <= ST_CALC;
                    end else if (line_start && cfg_valid) begin
                        step_reset <= 1'b1;
                        state      <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    count <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // A pixel coinciding with an abort is dropped so step_in never meets step_reset.
                    if (line_start) begin
                        step_reset <= 1'b1;
                        state      <= ST_RESET;
                    end else if (count >= disp_l) begin
                        state <= ST_WAIT;
                    end else if (pix_ce) begin
                        step_in <= 1'b1;
                        count   <= count + 1'b1;
                        if (count + 1'b1 == disp_l) state <= ST_WAIT;
                    end
                end
                default: state <= ST_CALC;
            endcase
        end
    end

endmodule
